// File: rtl/csr_machine_file.sv
// Machine-mode CSR file: M-mode registers, 64-bit cycle/instret counters,
// write/set/clear access, hardware trap entry and mret, live mip.
module csr_machine_file #(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      HARTID      = '0,
  parameter logic [XLEN-1:0]      MTVEC_RESET = '0,
  parameter int unsigned          COUNTERS_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      op,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            illegal,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic            irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
  localparam bit              HAS_CNT    = (COUNTERS_EN != 0);
  localparam bit              HAS_HI     = HAS_CNT && (XLEN == 32);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_val, mip_val, rd_val, wr_val;
  logic            mapped, read_only, eff_wr, do_wr;

  // MPP is hardwired to machine mode; only MIE and MPIE are real state.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mstatus_mpie_q;
    mstatus_val[3]     = mstatus_mie_q;
  end

  assign mip_val = XLEN'({irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000});

  // Address decode and combinational read mux.
  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (addr)
      A_MSTATUS:  begin mapped = 1'b1; rd_val = mstatus_val; end
      A_MIE:      begin mapped = 1'b1; rd_val = mie_q;       end
      A_MTVEC:    begin mapped = 1'b1; rd_val = mtvec_q;     end
      A_MSCRATCH: begin mapped = 1'b1; rd_val = mscratch_q;  end
      A_MEPC:     begin mapped = 1'b1; rd_val = mepc_q;      end
      A_MCAUSE:   begin mapped = 1'b1; rd_val = mcause_q;    end
      A_MIP:      begin mapped = 1'b1; rd_val = mip_val;     end
      A_MHARTID:  begin mapped = 1'b1; rd_val = HARTID;      end
      A_MCYCLE:   if (HAS_CNT) begin mapped = 1'b1; rd_val = mcycle_q[XLEN-1:0];   end
      A_MINSTRET: if (HAS_CNT) begin mapped = 1'b1; rd_val = minstret_q[XLEN-1:0]; end
      A_MCYCLEH:   if (HAS_HI) begin mapped = 1'b1; rd_val[31:0] = mcycle_q[63:32];   end
      A_MINSTRETH: if (HAS_HI) begin mapped = 1'b1; rd_val[31:0] = minstret_q[63:32]; end
      default: ;
    endcase
  end

  // Access legality and the value an effective write would store.
  always_comb begin
    case (op)
      2'b10:   wr_val = rd_val | din;
      2'b11:   wr_val = rd_val & ~din;
      default: wr_val = din;
    endcase
    // set/clear with a zero mask is a plain read with no side effects
    eff_wr    = (op == 2'b01) || (op[1] && (din != '0));
    read_only = (addr == A_MIP) || (addr == A_MHARTID);
    illegal   = (op != 2'b00) && (!mapped || (eff_wr && read_only));
    do_wr     = eff_wr && mapped && !read_only;
  end

  // Next-state: CSR writes first, then mret, then trap, so later
  // assignments give trap > mret > CSR access on the fields they touch.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + 64'(retire);

    if (do_wr) begin
      case (addr)
        A_MSTATUS: begin
          mstatus_mie_d  = wr_val[3];
          mstatus_mpie_d = wr_val[7];
        end
        A_MIE:       mie_d      = wr_val & MIE_MASK;
        A_MTVEC:     mtvec_d    = wr_val & ALIGN_MASK;
        A_MSCRATCH:  mscratch_d = wr_val;
        A_MEPC:      mepc_d     = wr_val & ALIGN_MASK;
        A_MCAUSE:    mcause_d   = wr_val;
        A_MCYCLE: begin
          mcycle_d             = mcycle_q;
          mcycle_d[XLEN-1:0]   = wr_val;
        end
        A_MINSTRET: begin
          minstret_d           = minstret_q;
          minstret_d[XLEN-1:0] = wr_val;
        end
        A_MCYCLEH: begin
          mcycle_d             = mcycle_q;
          mcycle_d[63:32]      = wr_val[31:0];
        end
        A_MINSTRETH: begin
          minstret_d           = minstret_q;
          minstret_d[63:32]    = wr_val[31:0];
        end
        default: ;
      endcase
    end

    if (mret && !trap) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (trap) begin
      mepc_d         = trap_pc & ALIGN_MASK;
      mcause_d       = trap_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end

    if (!HAS_CNT) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign dout        = rd_val;
  assign mstatus     = mstatus_val;
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;
  assign irq_pending = mstatus_mie_q & |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_machine_file.sv
// Directed bench for csr_machine_file (XLEN=32) with an expectation queue.
module tb_csr_machine_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        illegal;
  logic        irq_sw, irq_timer, irq_ext;
  logic        retire, trap, mret;
  logic [31:0] trap_cause, trap_pc;
  logic [31:0] mstatus, mtvec, mepc;
  logic        irq_pending;

  localparam int S_DOUT = 0, S_ILL = 1, S_IRQ = 2, S_MST = 3, S_MTVEC = 4, S_MEPC = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  csr_machine_file #(
    .XLEN(32), .HARTID(32'h0000_0005), .MTVEC_RESET(32'h0000_0103), .COUNTERS_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .addr(addr), .din(din), .dout(dout),
    .illegal(illegal), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .retire(retire), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret(mret), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_DOUT:  return dout;
      S_ILL:   return {31'd0, illegal};
      S_IRQ:   return {31'd0, irq_pending};
      S_MST:   return mstatus;
      S_MTVEC: return mtvec;
      default: return mepc;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  // compare every queued expectation against the outputs at the falling edge
  task automatic check_now();
    sb_t         e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    op = o; addr = a; din = d;
  endtask

  initial begin
    rst = 1'b1; op = 2'b00; addr = 12'h7C0; din = '0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0; retire = 0; trap = 0; mret = 0;
    trap_cause = '0; trap_pc = '0;
    tick(); tick();

    // reset state
    expect_val("rst_mstatus", S_MST, 32'h0000_1800);
    expect_val("rst_irq", S_IRQ, 32'd0);
    expect_val("rst_mtvec", S_MTVEC, 32'h0000_0100);
    expect_val("rst_mepc", S_MEPC, 32'd0);
    expect_val("rst_dout_unmapped", S_DOUT, 32'd0);
    check_now();
    tick();
    rst = 1'b0;

    // 1: write / read / clear mscratch
    drv(2'b01, 12'h340, 32'hDEAD_BEEF);
    expect_val("wr_pre_value", S_DOUT, 32'd0);
    expect_val("wr_legal", S_ILL, 32'd0);
    check_now(); tick();
    drv(2'b00, 12'h340, 32'd0);
    expect_val("mscratch_rd", S_DOUT, 32'hDEAD_BEEF);
    check_now(); tick();
    drv(2'b11, 12'h340, 32'h0000_00FF);
    expect_val("clr_pre_value", S_DOUT, 32'hDEAD_BEEF);
    check_now(); tick();
    drv(2'b00, 12'h340, 32'd0);
    expect_val("mscratch_clr", S_DOUT, 32'hDEAD_BE00);
    check_now(); tick();

    // 2: interrupts
    drv(2'b10, 12'h300, 32'h8); tick();
    drv(2'b10, 12'h304, 32'h80); tick();
    drv(2'b00, 12'h344, 32'd0); irq_timer = 1;
    expect_val("mip_timer", S_DOUT, 32'h80);
    expect_val("irq_timer_pend", S_IRQ, 32'd1);
    expect_val("mstatus_mie", S_MST, 32'h0000_1808);
    check_now(); tick();
    irq_timer = 0; irq_ext = 1;
    expect_val("mip_ext", S_DOUT, 32'h800);
    expect_val("irq_ext_masked", S_IRQ, 32'd0);
    check_now(); tick();
    irq_ext = 0;

    // 3: trap then mret
    trap = 1; trap_pc = 32'h1003; trap_cause = 32'h8000_0007; tick();
    trap = 0; drv(2'b00, 12'h342, 32'd0);
    expect_val("trap_mepc", S_MEPC, 32'h1000);
    expect_val("trap_mcause", S_DOUT, 32'h8000_0007);
    expect_val("trap_mstatus", S_MST, 32'h0000_1880);
    check_now(); tick();
    mret = 1; tick(); mret = 0;
    expect_val("mret_mstatus", S_MST, 32'h0000_1888);
    check_now(); tick();
    drv(2'b01, 12'h305, 32'h2003); tick();
    drv(2'b00, 12'h305, 32'd0);
    expect_val("mtvec_align", S_MTVEC, 32'h2000);
    check_now(); tick();

    // 4: counter wrap and write-suppressed increment
    drv(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drv(2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    drv(2'b00, 12'hB00, 32'd0); tick(); tick();
    expect_val("mcycle_wrap_lo", S_DOUT, 32'd1);
    check_now(); tick();
    addr = 12'hB80;
    expect_val("mcycle_wrap_hi", S_DOUT, 32'd0);
    check_now(); tick();
    drv(2'b01, 12'hB02, 32'd5); retire = 1; tick();
    drv(2'b00, 12'hB02, 32'd0); retire = 0;
    expect_val("minstret_wr_wins", S_DOUT, 32'd5);
    check_now(); tick();
    retire = 1; tick(); retire = 0;
    expect_val("minstret_inc", S_DOUT, 32'd6);
    check_now(); tick();

    // 5: illegal accesses
    drv(2'b01, 12'hF14, 32'd1);
    expect_val("hartid_wr_ill", S_ILL, 32'd1);
    expect_val("hartid_rd", S_DOUT, 32'd5);
    check_now(); tick();
    drv(2'b10, 12'hF14, 32'd0);
    expect_val("hartid_set0_legal", S_ILL, 32'd0);
    check_now(); tick();
    drv(2'b01, 12'h344, 32'h80);
    expect_val("mip_wr_ill", S_ILL, 32'd1);
    check_now(); tick();
    drv(2'b01, 12'h7C0, 32'h123);
    expect_val("unmapped_ill", S_ILL, 32'd1);
    expect_val("unmapped_dout", S_DOUT, 32'd0);
    check_now(); tick();
    drv(2'b00, 12'h7C0, 32'h123);
    expect_val("unmapped_none_legal", S_ILL, 32'd0);
    check_now(); tick();
    drv(2'b00, 12'h340, 32'd0);
    expect_val("no_state_change", S_DOUT, 32'hDEAD_BE00);
    check_now(); tick();

    // 6: priority trap > mret > CSR write
    drv(2'b01, 12'h300, 32'h80); tick();
    drv(2'b01, 12'h300, 32'h8); trap = 1; mret = 1;
    trap_pc = 32'h2000; trap_cause = 32'd3; tick();
    drv(2'b00, 12'h342, 32'd0); trap = 0; mret = 0;
    expect_val("prio_mstatus", S_MST, 32'h0000_1800);
    expect_val("prio_mepc", S_MEPC, 32'h2000);
    expect_val("prio_mcause", S_DOUT, 32'd3);
    check_now(); tick();
    drv(2'b01, 12'h340, 32'h55); trap = 1; trap_pc = 32'h3004; tick();
    drv(2'b00, 12'h340, 32'd0); trap = 0;
    expect_val("trap_other_wr", S_DOUT, 32'h55);
    expect_val("trap_other_mepc", S_MEPC, 32'h3004);
    check_now(); tick();
    drv(2'b01, 12'h300, 32'h80); tick();
    drv(2'b01, 12'h300, 32'h0); mret = 1; tick();
    drv(2'b00, 12'h300, 32'd0); mret = 0;
    expect_val("mret_over_wr", S_MST, 32'h0000_1888);
    check_now(); tick();

    // mid-sequence reset with concurrent trap and write
    rst = 1; drv(2'b01, 12'h340, 32'h77); trap = 1; trap_pc = 32'h4000; tick();
    rst = 0; trap = 0; drv(2'b00, 12'hB00, 32'd0);
    expect_val("rst2_mstatus", S_MST, 32'h0000_1800);
    expect_val("rst2_mepc", S_MEPC, 32'd0);
    expect_val("rst2_mtvec", S_MTVEC, 32'h0000_0100);
    expect_val("rst2_mcycle0", S_DOUT, 32'd0);
    check_now(); tick();
    expect_val("rst2_mcycle1", S_DOUT, 32'd1);
    check_now(); tick();
    addr = 12'h340;
    expect_val("rst2_mscratch", S_DOUT, 32'd0);
    check_now(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_machine_file.md
Name: csr_machine_file

Overview:
Parametrised machine-mode CSR file for the core. It holds the M-mode registers plus 64-bit cycle/instret counters, and supports write, set and clear operations. It also performs trap entry and mret state updates in hardware and reflects live interrupt lines into mip. It sits beside the execute stage: it feeds the read value back to the register writeback path, and supplies mtvec, mepc and irq_pending to the fetch/trap logic.

Parameters:
XLEN, 32, data width; legal values 32 or 64.
HARTID, 0, value returned by mhartid.
MTVEC_RESET, 0, reset value of mtvec; bits [1:0] are forced to 0.
COUNTERS_EN, 1, 1 implements mcycle/minstret (and the high halves when XLEN=32); 0 makes those addresses unmapped.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
op  in  2  00 none, 01 write, 10 set, 11 clear
addr  in  12  CSR address
din  in  XLEN  operand
dout  out  XLEN  current value at addr, combinational; 0 if unmapped
illegal  out  1  combinational; access is illegal (see Behaviour)
irq_sw, irq_timer, irq_ext  in  1 each  level interrupt inputs
retire  in  1  one instruction retired this cycle
trap  in  1  take trap this cycle
trap_cause  in  XLEN  cause to record
trap_pc  in  XLEN  pc to record
mret  in  1  execute mret this cycle
mstatus  out  XLEN  current mstatus
mtvec  out  XLEN  current mtvec
mepc  out  XLEN  current mepc
irq_pending  out  1  mstatus.MIE & |(mie & mip)

Behaviour:
- Address map:
  - mstatus 0x300
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mip 0x344
  - mcycle 0xB00
  - minstret 0xB02
  - mcycleh 0xB80 (XLEN=32 only)
  - minstreth 0xB82 (XLEN=32 only)
  - mhartid 0xF14
- Read-only registers: mip and mhartid.
- Field rules:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
  - mie: only bits 3/7/11 are writable.
  - mip: bit3=irq_sw, bit7=irq_timer, bit11=irq_ext, sampled live.
  - mtvec and mepc: bits [1:0] always read 0.
- Write value: write gives din; set gives old|din; clear gives old&~din. The update lands on the next posedge clk; dout shows the pre-update value in the access cycle.
- Set or clear with din==0 is a pure read: no write and no write side effects.
- illegal=1 when op!=00 and addr is unmapped, or when an effective write targets a read-only register. When illegal=1, no state changes from the access.
- Counters: mcycle increments every cycle after reset; minstret increments when retire=1. Both are 64-bit and wrap from all-ones to 0.
  - XLEN=32: low and high halves are individually accessible.
  - A CSR write to any half of a counter takes effect that cycle and suppresses that counter's increment for that cycle.
- Trap entry (trap=1): mepc<=trap_pc&~3; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
- mret=1: MIE<=MPIE; MPIE<=1.
- Priority in one cycle: trap > mret > CSR access to the same register.
  - trap and mret together: trap only.
  - A CSR write to mstatus/mepc/mcause in a trap cycle is discarded. Writes to other registers still apply.
  - A CSR write to mstatus in an mret cycle is discarded.
- Reset (rst=1 at posedge): all state is 0, except mtvec=MTVEC_RESET&~3. Counters restart from 0 on the following cycle. Reset overrides every concurrent trap, mret or access.
- Reset output values: dout=0 for unmapped addresses; mstatus=0x1800; irq_pending=0.

Test Plan:
1. Reset, then op=01 addr=0x340 din=0xDEADBEEF; next cycle op=00 -> dout=0xDEADBEEF; then op=11 din=0xFF -> dout=0xDEADBE00.
2. Set MIE (op=10 0x300 din=0x8) and mie bit7; raise irq_timer -> mip reads 0x80 and irq_pending=1; drop irq_timer -> irq_pending=0.
3. MIE=1, trap with trap_pc=0x1003 and cause=0x80000007 -> mepc=0x1000, mcause=0x80000007, mstatus=0x1880; then mret -> mstatus=0x1888.
4. Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF (XLEN=32), then idle 2 cycles -> mcycleh=0 and mcycle=1. Assert retire during a minstret write of 5 -> minstret=5, not 6.
5. op=01 on addr 0xF14 -> illegal=1 and dout=HARTID; op=10 din=0 on 0xF14 -> illegal=0. op=01 on addr 0x7C0 -> illegal=1, dout=0, no state change.
6. trap, mret and an mstatus write in the same cycle -> only the trap effect is applied. Assert rst mid-sequence -> all registers return to reset values the next cycle.
